// File: rtl/sp_ram_fifo_ctrl_pkg.sv
// Shared width helpers for the sp_ram FIFO controller slice.
package sp_ram_fifo_ctrl_pkg;

  // Counter width able to hold 0..depth (and the small overshoot from the output buffer).
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sp_ram_fifo_ctrl_obuf2.sv
// Two-entry register FIFO holding prefetched RAM words for the downstream port.
module sp_ram_fifo_ctrl_obuf2 #(
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  logic                  push_ok;
  logic                  pop_ok;

  // Qualify pop by occupancy; a push into a full buffer only lands if a pop frees a slot.
  always_comb begin
    pop_ok  = pop && (count != 2'd0);
    push_ok = push && ((count != 2'd2) || pop_ok);
    valid   = (count != 2'd0);
    head    = slot0;
  end

  // Slot 0 is always the head; pops shift slot 1 forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !push_ok));

endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// Valid/ready FIFO controller driving an external single-port RAM, with a
// two-word prefetch buffer on the output side.
module sp_ram_fifo_ctrl
  import sp_ram_fifo_ctrl_pkg::*;
#(
  parameter  int unsigned NUMBER_OF_LINES = 8192,
  parameter  int unsigned DATA_WIDTH      = 128,
  localparam int unsigned CNT_W           = cnt_width(NUMBER_OF_LINES),
  localparam int unsigned AW              = $clog2(NUMBER_OF_LINES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      fill_level,
  output logic                  ram_cs,
  output logic                  ram_w_en,
  output logic [AW-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  input  logic                  ram_mem_valid
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(NUMBER_OF_LINES);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] ram_used;
  logic             inflight;
  logic             post_rst;
  logic [1:0]       obuf_cnt;
  logic [1:0]       pend;
  logic             rd_pref;
  logic             wr_go;
  logic             rd_go;

  // Arbitration: a read is forced only when nothing is buffered or in flight;
  // otherwise writes win and prefetch uses the idle-write cycles.
  always_comb begin
    pend        = obuf_cnt + {1'b0, inflight};
    rd_pref     = (pend == 2'd0) && (ram_used != '0);
    in_ready    = (ram_used < DEPTH) && !rd_pref;
    wr_go       = in_valid && in_ready;
    rd_go       = rd_pref || ((ram_used != '0) && (pend < 2'd2) && !wr_go);
    ram_cs      = wr_go || rd_go;
    ram_w_en    = wr_go;
    ram_addr    = wr_go ? wr_ptr : rd_ptr;
    ram_wr_data = in_data;
    fill_level  = ram_used + CNT_W'(inflight) + CNT_W'(obuf_cnt);
  end

  // Pointers, RAM occupancy and the read-in-flight flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_used <= '0;
      inflight <= 1'b0;
      post_rst <= 1'b0;
    end else begin
      if (wr_go) wr_ptr <= wr_ptr + AW'(1);
      if (rd_go) rd_ptr <= rd_ptr + AW'(1);
      if (wr_go)      ram_used <= ram_used + CNT_W'(1);
      else if (rd_go) ram_used <= ram_used - CNT_W'(1);
      inflight <= rd_go;
      post_rst <= 1'b1;
    end
  end

  // Capture is keyed on inflight alone so a stale RAM strobe after reset is dropped.
  sp_ram_fifo_ctrl_obuf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (ram_rd_data),
    .pop       (out_ready),
    .count     (obuf_cnt),
    .valid     (out_valid),
    .head      (out_data)
  );

  // The first edge after reset may still see a strobe from a read issued before reset.
  a_mem_valid: assert property (@(posedge clk) disable iff (!rst_n)
    post_rst |-> (ram_mem_valid == inflight));

  a_excl: assert property (@(posedge clk) disable iff (!rst_n) !(wr_go && rd_go));

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Randomized bench for sp_ram_fifo_ctrl with a queue-based reference model.
module tb_sp_ram_fifo_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] fill_level;
  logic          ram_cs;
  logic          ram_w_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic [DW-1:0] ram_rd_data;
  logic          ram_mem_valid = 1'b0;

  logic [DW-1:0] ram_mem [N];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [DW-1:0] q[$];
  int unsigned   wr_cnt = 0;
  int unsigned   rd_cnt = 0;

  always #5 clk = ~clk;

  sp_ram_fifo_ctrl #(
    .NUMBER_OF_LINES(N),
    .DATA_WIDTH     (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .fill_level   (fill_level),
    .ram_cs       (ram_cs),
    .ram_w_en     (ram_w_en),
    .ram_addr     (ram_addr),
    .ram_wr_data  (ram_wr_data),
    .ram_rd_data  (ram_rd_data),
    .ram_mem_valid(ram_mem_valid)
  );

  // External single-port RAM: no reset, 1-cycle registered read, X when idle.
  always @(posedge clk) begin
    if (ram_cs && !ram_w_en) ram_rd_data <= ram_mem[ram_addr];
    else                     ram_rd_data <= 'x;
    if (ram_cs && ram_w_en)  ram_mem[ram_addr] <= ram_wr_data;
    ram_mem_valid <= ram_cs && !ram_w_en;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then update it.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, output logic acc);
    logic popped;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    check("fill_level", 64'(fill_level), 64'(q.size()));
    acc    = v && in_ready;
    popped = out_valid && r;
    if (acc) begin
      check("wr_cs", 64'(ram_cs), 64'd1);
      check("wr_en", 64'(ram_w_en), 64'd1);
      check("wr_addr", 64'(ram_addr), 64'(wr_cnt % N));
      check("wr_data", 64'(ram_wr_data), 64'(d));
    end else begin
      check("no_wr_en", 64'(ram_w_en), 64'd0);
      if (ram_cs) begin
        check("rd_addr", 64'(ram_addr), 64'(rd_cnt % N));
        check("rd_has_data", 64'(rd_cnt < wr_cnt), 64'd1);
      end
      if (wr_cnt == rd_cnt) check("idle_cs", 64'(ram_cs), 64'd0);
    end
    if (out_valid) begin
      if (q.size() == 0) check("spurious_valid", 64'(out_valid), 64'd0);
      else               check("out_data", 64'(out_data), 64'(q[0]));
    end
    if (ram_cs && !ram_w_en) rd_cnt++;
    if (acc) begin
      q.push_back(d);
      wr_cnt++;
    end
    if (popped && q.size() != 0) void'(q.pop_front());
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 60 && q.size() != 0; i++) step(1'b0, '0, 1'b1, a);
    check("drain_empty", 64'(q.size()), 64'd0);
    step(1'b0, '0, 1'b0, a);
    check("drain_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    int unsigned acc_cnt;
    int unsigned k;
    logic found;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_fill", 64'(fill_level), 64'd0);
    check("rst_cs", 64'(ram_cs), 64'd0);
    check("rst_w_en", 64'(ram_w_en), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // Empty-FIFO latency with 0xA5
    step(1'b1, 16'h00A5, 1'b0, a);
    check("lat_acc", 64'(a), 64'd1);
    step(1'b0, '0, 1'b0, a);
    check("lat_rd_cs", 64'(ram_cs), 64'd1);
    check("lat_rd_wen", 64'(ram_w_en), 64'd0);
    check("lat_rd_addr", 64'(ram_addr), 64'd0);
    check("lat_c1_valid", 64'(out_valid), 64'd0);
    step(1'b0, '0, 1'b0, a);
    check("lat_c2_valid", 64'(out_valid), 64'd0);
    check("lat_c2_cs", 64'(ram_cs), 64'd0);
    step(1'b0, '0, 1'b1, a);
    check("lat_c3_valid", 64'(out_valid), 64'd1);
    check("lat_c3_data", 64'(out_data), 64'h00A5);
    step(1'b0, '0, 1'b0, a);
    check("lat_fill_after", 64'(fill_level), 64'd0);

    // Fill to capacity with no pops: 8 in RAM plus 2 in the output buffer
    acc_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, DW'($urandom), 1'b0, a);
      if (a) acc_cnt++;
    end
    check("full_accepted", 64'(acc_cnt), 64'd10);
    step(1'b0, '0, 1'b0, a);
    check("full_fill", 64'(fill_level), 64'd10);
    check("full_in_ready", 64'(in_ready), 64'd0);
    step(1'b0, '0, 1'b1, a);
    found = 1'b0;
    for (int i = 0; i < 3 && !found; i++) begin
      step(1'b0, '0, 1'b0, a);
      if (in_ready) found = 1'b1;
    end
    check("full_ready_back", 64'(found), 64'd1);
    drain();

    // 20 sequential words through depth 8 with random backpressure
    k = 0;
    for (int i = 0; i < 400 && k < 20; i++) begin
      step(1'b1, DW'(k), 1'($urandom_range(0, 1)), a);
      if (a) k++;
    end
    check("seq_all_pushed", 64'(k), 64'd20);
    drain();

    // Backpressure hold: head stays put and reads stop once two words are pending
    k = 0;
    for (int i = 0; i < 40 && k < 5; i++) begin
      step(1'b1, DW'(16'h1000 + k), 1'b0, a);
      if (a) k++;
    end
    repeat (6) step(1'b0, '0, 1'b0, a);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, a);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'h1000);
      check("bp_no_read", 64'(ram_cs), 64'd0);
    end
    drain();

    // Random traffic
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), a);
    drain();

    // Reset while a read is in flight
    step(1'b1, 16'h0011, 1'b0, a);
    step(1'b0, '0, 1'b0, a);
    check("mr_rd_issue", 64'(ram_cs && !ram_w_en), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    wr_cnt = 0;
    rd_cnt = 0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, a);
      check("mr_no_valid", 64'(out_valid), 64'd0);
      check("mr_fill", 64'(fill_level), 64'd0);
    end
    step(1'b1, 16'h003C, 1'b0, a);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, '0, 1'b0, a);
      if (out_valid) found = 1'b1;
    end
    check("mr_valid_seen", 64'(found), 64'd1);
    check("mr_data", 64'(out_data), 64'h003C);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_ram_fifo_ctrl.md
# sp_ram_fifo_ctrl

Initiator-side controller that turns an external `sp_ram` (one access per cycle, 1-cycle registered read, `mem_valid` strobe) into a valid/ready FIFO. Upstream pushes words, and the controller writes them into the RAM. It prefetches words back into a 2-entry output buffer and presents them downstream. It sits between pipeline stages that need deep buffering, for example line/rate buffers, with `sp_ram` instantiated beside it at the same level.

## Interface
- `NUMBER_OF_LINES`, 8192: RAM depth; power of 2, ≥4.
- `DATA_WIDTH`, 128: word width.
- `CNT_W`, `$clog2(NUMBER_OF_LINES)+1` (localparam): counter width.

- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: push request.
- `in_ready` out 1: push accepted when `in_valid & in_ready`.
- `in_data` in DATA_WIDTH: push word.
- `out_valid` out 1: head word available.
- `out_ready` in 1: pop when `out_valid & out_ready`.
- `out_data` out DATA_WIDTH: head word.
- `fill_level` out CNT_W: words held (RAM + in flight + output buffer).
- `ram_cs` out 1: RAM chip select, combinational.
- `ram_w_en` out 1: RAM write enable, combinational.
- `ram_addr` out `$clog2(NUMBER_OF_LINES)`: RAM address.
- `ram_wr_data` out DATA_WIDTH: equals `in_data`.
- `ram_rd_data` in DATA_WIDTH: RAM read data; X when not reading.
- `ram_mem_valid` in 1: RAM read-valid strobe (RAM side has no reset).

## Operation
- State:
  - `wr_ptr` and `rd_ptr` wrap modulo NUMBER_OF_LINES.
  - `ram_used` (CNT_W) is words written and not yet read-issued.
  - `inflight` is a flag for a read issued last cycle.
  - `obuf_cnt` (0..2) is the output buffer occupancy.
- `pend = obuf_cnt + inflight`.
- Read preference: `rd_pref = (pend==0) & (ram_used!=0)`.
- Read issue: `rd_go = (ram_used!=0) & (pend<2) & ~(in_valid & in_ready)`, or whenever `rd_pref` holds.
- Write: `in_ready = (ram_used < NUMBER_OF_LINES) & ~rd_pref`. Does not depend on `in_valid`.
- `wr_go = in_valid & in_ready`. `wr_go` and `rd_go` are mutually exclusive by construction.
- RAM drive:
  - `ram_cs = wr_go | rd_go`; `ram_w_en = wr_go`.
  - `ram_addr = wr_go ? wr_ptr : rd_ptr`.
- `ram_used` update: +1 on `wr_go`, −1 on `rd_go`. The two never occur in the same cycle.
- `inflight <= rd_go`.
- Capture: when `inflight` is 1, push `ram_rd_data` into the output buffer. `ram_mem_valid` is checked by assertion to equal `inflight`, but capture is qualified by `inflight` only.
- The output buffer handles capture and pop in the same cycle; `obuf_cnt` stays unchanged in that case.
- `fill_level = ram_used + inflight + obuf_cnt`. Maximum is NUMBER_OF_LINES+2.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `fill_level=0`.
  - `ram_cs=0`, `ram_w_en=0`, `ram_addr=0`.
  - `in_ready=1`.
  - Pointers, `ram_used`, `inflight` and `obuf_cnt` are 0.
- Empty-FIFO latency: a push accepted in cycle 0 is written at the end of cycle 0. Read issues in cycle 1. Data returns in cycle 2. `out_valid=1` in cycle 3.
- Sustained throughput:
  - With both sides active, reads take priority only when the buffer pipeline is empty. Otherwise writes win.
  - The prefetch uses idle-write cycles.
  - A continuously streaming pair averages at least 1 word per 2 cycles.
- Full: `in_ready=0` when `ram_used==NUMBER_OF_LINES`. `in_ready` rises the cycle after the first read issue.
- Empty: `out_valid=0` when `obuf_cnt==0`. `ram_cs` stays low when there is no push and `ram_used==0`.
- Wrap: pointers roll from NUMBER_OF_LINES−1 to 0 with no data corruption.
- Mid-operation reset: all contents are discarded. A `ram_mem_valid` pulse arriving after reset deassertion is ignored (`inflight=0`).
- `out_data` holds stable while `out_valid & ~out_ready`.

## Structure
- No shared package entries beyond the existing width helpers. `CNT_W` is a local parameter.
- One natural sub-module: `obuf2`, a 2-entry register FIFO with count, push, pop and head-out.
- `sp_ram` is instantiated by the parent, not inside this block.

## Test plan
- Single push `0xA5` into empty FIFO -> RAM write at address 0 in cycle 0, read at address 0 in cycle 1, `out_valid` in cycle 3 with `out_data=0xA5`, `fill_level` returns to 0 after pop.
- NUMBER_OF_LINES=8, `out_ready=0`, push 12 words -> 10 accepted (8 RAM + 2 buffer), `in_ready=0`, `fill_level=10`. Pop one -> `in_ready` reasserts within 2 cycles.
- Push 20 sequential words through depth 8 with random `out_ready` -> order preserved across pointer wrap and `ram_addr` cycles 0..7.
- Random `in_valid`/`out_ready` for 10k cycles -> scoreboard exact match. Never `wr_go & rd_go`. `fill_level` always equals the scoreboard count.
- Assert `rst_n` for 1 cycle while a read is in flight -> no spurious `out_valid`, `fill_level=0`, next push `0x3C` pops as `0x3C`.
- Backpressure hold: `out_valid=1`, `out_ready=0` for 5 cycles -> `out_data` constant, no RAM reads once `pend==2`.
